protected_access_ctrl: RTL
==========================

PROTECTED_ACCESS_CTRL -- requirements
Module: protected_access_ctrl

Interface
REQ-001 Parameter BUS_WIDTH SHALL default 32; it is the address width.
REQ-002 Parameter ENTRY_NUM SHALL default 4; it is the number of write-once protected-address entries, and IDX_W = clog2(ENTRY_NUM).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cfg_valid  input  1  SHALL signal a request to program one protection entry.
REQ-006 cfg_idx  input  IDX_W  SHALL select the entry being programmed.
REQ-007 cfg_addr  input  BUS_WIDTH  SHALL be the address to protect.
REQ-008 cfg_ready  output  1  SHALL indicate that the config request is accepted this cycle.
REQ-009 cfg_err  output  1  SHALL pulse for 1 cycle when a config targets an already-set entry.
REQ-010 acc_valid, acc_write, acc_addr  input  1,1,BUS_WIDTH  SHALL carry the upstream access request.
REQ-011 acc_ready  output  1  SHALL indicate that the upstream access is accepted.
REQ-012 grant_valid, grant_write, grant_addr  output  1,1,BUS_WIDTH  SHALL carry the downstream forwarded access.
REQ-013 grant_ready  input  1  SHALL be the downstream acceptance.
REQ-014 fault  output  1  SHALL pulse for 1 cycle on a blocked access; fault_addr (BUS_WIDTH) SHALL hold the last blocked address.
REQ-015 lock_mask  output  ENTRY_NUM  SHALL provide the per-entry set flags.

Function
REQ-016 Each entry SHALL be write-once: the first accepted config stores cfg_addr and sets lock_mask[idx]; any later config to that entry SHALL be accepted, leave the entry unchanged, and pulse cfg_err on the cycle after acceptance.
REQ-017 The FSM SHALL have the states IDLE, CHECK, FORWARD and FAULT.
REQ-018 acc_ready SHALL be asserted only in IDLE; acc_valid&&acc_ready SHALL capture acc_addr and acc_write and move the FSM to CHECK.
REQ-019 cfg_ready SHALL equal (state==IDLE)&&!acc_valid, so an access wins over a config that arrives in the same cycle; the config SHALL stay pending without loss.
REQ-020 In CHECK, a captured write whose address equals the address of any set entry SHALL go to FAULT; otherwise the FSM SHALL go to FORWARD. Reads SHALL never fault.
REQ-021 In FORWARD, grant_valid SHALL be 1 with the captured fields held stable until grant_ready, then the FSM SHALL return to IDLE; the minimum acc-accept-to-grant latency is 2 cycles.
REQ-022 In FAULT, fault SHALL be 1 and fault_addr SHALL load the captured address for exactly 1 cycle, after which the FSM SHALL return to IDLE; no grant SHALL be issued for that access.
REQ-023 An entry set by a config SHALL take effect for any access captured on a later cycle.
REQ-024 The address compare SHALL be an exact full-width BUS_WIDTH compare; an unset entry SHALL never match, including address 0.

Reset
REQ-025 When reset is high at a clock edge, the FSM SHALL go to IDLE and every output SHALL read 0: lock_mask, all entry addresses, fault_addr, grant fields, fault and cfg_err.
REQ-026 A reset in CHECK, FORWARD or FAULT SHALL abort the access without a grant or fault, and all entries SHALL be unlocked and reprogrammable afterwards.
REQ-027 While reset is high, acc_ready and cfg_ready SHALL be 0.

Structure
REQ-028 The FSM state encoding and the default BUS_WIDTH/ENTRY_NUM values SHALL live in the shared package protected_pkg.
REQ-029 Each entry SHALL be one instance of the existing protected_flag sub-module, which supplies set, protected_addr_in, protected_flag and protected_addr; its active-low reset SHALL be driven as ~reset.

Verification
REQ-030 Reset, cfg idx0=3, then write to 3 -> cfg accepted, lock_mask=0001, fault=1 for 1 cycle, fault_addr=3, no grant_valid.
REQ-031 cfg idx0=2 after idx0=3 -> cfg_err pulse, entry0 stays 3; a write to 2 is granted 2 cycles after acceptance.
REQ-032 Read from 3, grant_ready held low 3 cycles -> grant_valid and grant_addr=3 stable, acc_ready=0 until completion.
REQ-033 cfg_valid and acc_valid in the same cycle in IDLE -> access accepted first, cfg accepted in the first IDLE cycle with acc_valid=0.
REQ-034 Reset during FORWARD -> grant_valid=0 next cycle, lock_mask=0; a subsequent write to 3 is granted.
REQ-035 Unset entries with a write to address 0 -> granted with no fault.

Source files
------------

// File: rtl/protected_access_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : protected_pkg                                              |
// | Description : Shared defaults, FSM state codes and index-width helper.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package protected_pkg;

    localparam int c_BUS_WIDTH_DEFAULT = 32;
    localparam int c_ENTRY_NUM_DEFAULT = 4;

    localparam int c_STATE_W = 2;
    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 2'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CHECK   = 2'd1;
    localparam logic [c_STATE_W-1:0] c_ST_FORWARD = 2'd2;
    localparam logic [c_STATE_W-1:0] c_ST_FAULT   = 2'd3;

    // A single entry still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/protected_access_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : protected_access_ctrl_if                                   |
// | Description : Config, upstream access, downstream grant and status bus.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface protected_access_ctrl_if
    import protected_pkg::*;
#(
    parameter int BUS_WIDTH = c_BUS_WIDTH_DEFAULT,
    parameter int ENTRY_NUM = c_ENTRY_NUM_DEFAULT
) ();

    localparam int c_IDX_W = idx_width(ENTRY_NUM);

    logic                 cfg_valid;
    logic [c_IDX_W-1:0]   cfg_idx;
    logic [BUS_WIDTH-1:0] cfg_addr;
    logic                 cfg_ready;
    logic                 cfg_err;

    logic                 acc_valid;
    logic                 acc_write;
    logic [BUS_WIDTH-1:0] acc_addr;
    logic                 acc_ready;

    logic                 grant_valid;
    logic                 grant_write;
    logic [BUS_WIDTH-1:0] grant_addr;
    logic                 grant_ready;

    logic                 fault;
    logic [BUS_WIDTH-1:0] fault_addr;
    logic [ENTRY_NUM-1:0] lock_mask;

    modport master (
        output cfg_valid, cfg_idx, cfg_addr, acc_valid, acc_write, acc_addr, grant_ready,
        input  cfg_ready, cfg_err, acc_ready, grant_valid, grant_write, grant_addr,
               fault, fault_addr, lock_mask
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_addr, acc_valid, acc_write, acc_addr, grant_ready,
        output cfg_ready, cfg_err, acc_ready, grant_valid, grant_write, grant_addr,
               fault, fault_addr, lock_mask
    );

endinterface
`default_nettype wire

// File: rtl/protected_access_ctrl_flag.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : protected_flag                                             |
// | Description : One write-once protected-address entry.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module protected_flag #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set,
    input  logic [BUS_WIDTH-1:0] protected_addr_in,
    output logic                 protected_flag,
    output logic [BUS_WIDTH-1:0] protected_addr
);

    logic                 r_flag;
    logic [BUS_WIDTH-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag <= 1'b0;
            r_addr <= '0;
        end else if (set && !r_flag) begin
            r_flag <= 1'b1;
            r_addr <= protected_addr_in;
        end
    end

    assign protected_flag = r_flag;
    assign protected_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/protected_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : protected_access_ctrl                                      |
// | Description : Forwards accesses, blocking writes to locked addresses.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module protected_access_ctrl
    import protected_pkg::*;
#(
    parameter int BUS_WIDTH = c_BUS_WIDTH_DEFAULT,
    parameter int ENTRY_NUM = c_ENTRY_NUM_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    protected_access_ctrl_if.slave bus
);

    localparam int c_IDX_W = idx_width(ENTRY_NUM);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [BUS_WIDTH-1:0] r_acc_addr;
    logic                 r_acc_write;
    logic [BUS_WIDTH-1:0] r_fault_addr;
    logic                 r_cfg_err;

    logic [ENTRY_NUM-1:0] w_lock_mask;
    logic [ENTRY_NUM-1:0] w_sel;
    logic [ENTRY_NUM-1:0] w_match;
    logic [BUS_WIDTH-1:0] w_entry_addr [ENTRY_NUM];

    logic w_acc_ready, w_cfg_ready, w_acc_fire, w_cfg_fire;
    logic w_idx_locked, w_blocked;
    logic w_grant_valid, w_grant_write, w_fault;
    logic [BUS_WIDTH-1:0] w_grant_addr;

    // An access in the same cycle holds the config off; it stays pending upstream.
    assign w_acc_ready  = (r_state == c_ST_IDLE) && !reset;
    assign w_cfg_ready  = w_acc_ready && !bus.acc_valid;
    assign w_acc_fire   = bus.acc_valid && w_acc_ready;
    assign w_cfg_fire   = bus.cfg_valid && w_cfg_ready;
    assign w_idx_locked = |(w_lock_mask & w_sel);
    assign w_blocked    = r_acc_write && (|w_match);

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
        localparam logic [c_IDX_W-1:0] c_IDX = c_IDX_W'(i);

        assign w_sel[i]   = (bus.cfg_idx == c_IDX);
        assign w_match[i] = w_lock_mask[i] && (w_entry_addr[i] == r_acc_addr);

        protected_flag #(
            .BUS_WIDTH (BUS_WIDTH)
        ) u_flag (
            .clk               (clk),
            .rst_n             (~reset),
            .set               (w_cfg_fire && w_sel[i]),
            .protected_addr_in (bus.cfg_addr),
            .protected_flag    (w_lock_mask[i]),
            .protected_addr    (w_entry_addr[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (w_acc_fire) w_state_next = c_ST_CHECK;
            c_ST_CHECK:   w_state_next = w_blocked ? c_ST_FAULT : c_ST_FORWARD;
            c_ST_FORWARD: if (bus.grant_ready) w_state_next = c_ST_IDLE;
            c_ST_FAULT:   w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_write = 1'b0;
        w_grant_addr  = '0;
        w_fault       = 1'b0;
        case (r_state)
            c_ST_FORWARD: begin
                w_grant_valid = 1'b1;
                w_grant_write = r_acc_write;
                w_grant_addr  = r_acc_addr;
            end
            c_ST_FAULT:   w_fault = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_addr   <= '0;
            r_acc_write  <= 1'b0;
            r_fault_addr <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            if (w_acc_fire) begin
                r_acc_addr  <= bus.acc_addr;
                r_acc_write <= bus.acc_write;
            end
            if ((r_state == c_ST_CHECK) && w_blocked) begin
                r_fault_addr <= r_acc_addr;
            end
            r_cfg_err <= w_cfg_fire && w_idx_locked;
        end
    end

    assign bus.acc_ready   = w_acc_ready;
    assign bus.cfg_ready   = w_cfg_ready;
    assign bus.cfg_err     = r_cfg_err;
    assign bus.grant_valid = w_grant_valid;
    assign bus.grant_write = w_grant_write;
    assign bus.grant_addr  = w_grant_addr;
    assign bus.fault       = w_fault;
    assign bus.fault_addr  = r_fault_addr;
    assign bus.lock_mask   = w_lock_mask;

endmodule
`default_nettype wire
